iterative_divider: RTL

ITERATIVE_DIVIDER -- requirements
Module: iterative_divider

---
 rtl/iterative_divider.sv | 118 +++++++++++
 1 files changed

// File: rtl/iterative_divider.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU/REM/REMU) with an IDLE/CALC/FIN FSM.
// Define DIVIDER_EARLY_OUT_EN to let divide-by-zero and signed overflow skip CALC.
module iterative_divider (
    input  logic        clk,
    input  logic        rstN,
    input  logic        req,
    output logic        ready,
    input  logic        signOp,
    input  logic        remOp,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {StIdle, StCalc, StFin} state_t;

    state_t      state;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [31:0] divisor;
    logic [5:0]  cnt;
    logic        rem_sel;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic        div_zero;
    logic [32:0] shifted;
    logic [33:0] diff;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    always_comb begin
        abs1     = (signOp && op1[31]) ? (32'd0 - op1) : op1;
        abs2     = (signOp && op2[31]) ? (32'd0 - op2) : op2;
        div_zero = (op2 == 32'd0);
        shifted  = {rem, quot[31]};
        diff     = {1'b0, shifted} - {2'b00, divisor};
        q_fin    = neg_q ? (32'd0 - quot) : quot;
        r_fin    = neg_r ? (32'd0 - rem) : rem;
    end

`ifdef DIVIDER_EARLY_OUT_EN
    logic overflow;
    assign overflow = signOp && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);
`endif

    assign ready = (state == StIdle);
    assign busy  = ~ready;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state   <= StIdle;
            done    <= 1'b0;
            result  <= 32'd0;
            cnt     <= 6'd0;
            quot    <= 32'd0;
            rem     <= 32'd0;
            divisor <= 32'd0;
            rem_sel <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= StIdle;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (req) begin
                            divisor <= abs2;
                            rem_sel <= remOp;
                            // Divide-by-zero keeps an all-ones quotient regardless of sign.
                            neg_q   <= signOp && (op1[31] ^ op2[31]) && !div_zero;
                            neg_r   <= signOp && op1[31];
                            quot    <= abs1;
                            rem     <= 32'd0;
                            cnt     <= 6'd32;
                            state   <= StCalc;
`ifdef DIVIDER_EARLY_OUT_EN
                            if (div_zero || overflow) begin
                                quot  <= div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
                                rem   <= div_zero ? abs1 : 32'd0;
                                cnt   <= 6'd0;
                                state <= StFin;
                            end
`endif
                        end
                    end
                    StCalc: begin
                        if (!diff[33]) begin
                            rem  <= diff[31:0];
                            quot <= {quot[30:0], 1'b1};
                        end else begin
                            rem  <= shifted[31:0];
                            quot <= {quot[30:0], 1'b0};
                        end
                        cnt <= cnt - 6'd1;
                        if (cnt == 6'd1) begin
                            state <= StFin;
                        end
                    end
                    StFin: begin
                        result <= rem_sel ? r_fin : q_fin;
                        done   <= 1'b1;
                        state  <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule
